mem_to_axi_unpacker: RTL and testbench
======================================

# mem_to_axi_unpacker

Read-direction counterpart of the AXI-to-memory packing buffer. It fetches 128-bit words from the on-chip memory and streams each one as four 32-bit AXI read-data beats, least-significant beat first. A two-entry word buffer prefetches the next word, so with `axi_rready_i` held high the block sustains one beat per cycle with no bubbles between words. It sits between the TPU on-chip memory read port and the AXI slave read-data channel.

## Interface
Parameters:
- `AXI_DATA_WIDTH`, default 32: AXI beat width.
- `MEM_DATA_WIDTH`, default 128: memory word width; must equal 4 × `AXI_DATA_WIDTH`.
- `MEM_ADDR_WIDTH`, default 10: memory word address width.
- `LEN_WIDTH`, default 8: width of the word-count field.

Ports:
- `clk`  in  1: single clock, all logic on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `start_i`  in  1: one-cycle transfer request; sampled only in IDLE.
- `base_addr_i`  in  `MEM_ADDR_WIDTH`: first word address, latched on accepted start.
- `word_cnt_i`  in  `LEN_WIDTH`: number of memory words to stream, latched on accepted start.
- `busy_o`  out  1: high from accepted start until done.
- `done_o`  out  1: one-cycle pulse at end of transfer.
- `mem_ce_o`  out  1: memory read enable.
- `mem_addr_o`  out  `MEM_ADDR_WIDTH`: memory read address.
- `mem_rdata_i`  in  `MEM_DATA_WIDTH`: read data, valid the cycle after `mem_ce_o`.
- `axi_rdata_o`  out  `AXI_DATA_WIDTH`: beat data.
- `axi_rvalid_o`  out  1: beat valid.
- `axi_rlast_o`  out  1: last beat of the transfer.
- `axi_rready_i`  in  1: downstream ready.

## Operation
States:
- IDLE:
  - `start_i` with `word_cnt_i` ≠ 0: latch the inputs, go to RUN.
  - `start_i` with `word_cnt_i` = 0: go to DONE directly; no memory access, no beats.
- RUN: fetch and stream concurrently.
  - Exit to DONE on the handshake of the final beat.
- DONE: assert `done_o` for one cycle, then return to IDLE.

`start_i` is ignored outside IDLE.

Fetch engine:
- Occupancy counts filled slots plus reads in flight, range 0..2, registered.
- Issue `mem_ce_o` when occupancy < 2 (value at the start of the cycle) and words remain to fetch.
- `mem_addr_o` = base + fetch index, modulo 2^`MEM_ADDR_WIDTH`; wraps silently.
- Read data is captured into the tail slot the cycle after issue.
- At most one read is issued per cycle; reads land in order.

Stream engine:
- `axi_rvalid_o` is high while the head slot is filled.
- `axi_rdata_o` = head slot bits [k×32 +: 32], where k is the beat index 0..3. This is the same ordering the packer writes.
- A handshake (`axi_rvalid_o` and `axi_rready_i` both high) advances k.
- The handshake at k = 3 pops the head slot and resets k to 0.
- `axi_rlast_o` is high only with k = 3 on the final word.
- While `axi_rvalid_o` is high and `axi_rready_i` is low, `axi_rdata_o` and `axi_rlast_o` hold stable.
- `axi_rdata_o` is 0 whenever `axi_rvalid_o` is low.

Width and counter rules:
- The word counter is `LEN_WIDTH` bits; the maximum transfer is 2^`LEN_WIDTH`−1 words.
- The beat index is a 2-bit counter.

## Timing
- Reset: `rst` high at a rising edge returns all state to its reset value at that edge, including mid-transfer.
  - State → IDLE; both slots invalid; occupancy, k and counters → 0.
  - Every output → 0 (`busy_o`, `done_o`, `mem_ce_o`, `mem_addr_o`, `axi_rdata_o`, `axi_rvalid_o`, `axi_rlast_o`).
  - No `done_o` pulse follows an aborted transfer.
- Start latency (start accepted at cycle 0):
  - Cycle 1: `busy_o` high; `mem_ce_o` high with `mem_addr_o` = base.
  - Cycle 2: `mem_rdata_i` valid; captured into a slot.
  - Cycle 3: `axi_rvalid_o` high with beat 0.
- Throughput with `axi_rready_i` = 1: N words produce 4N beats on consecutive cycles 3 … 4N+2.
  - `axi_rlast_o` is high on cycle 4N+2.
  - `done_o` is high on cycle 4N+3, with `busy_o` low on the same cycle.
  - A new start is accepted on cycle 4N+4.
- Zero-length start: `done_o` on cycle 1; `busy_o` stays low.
- Back-pressure: when `axi_rready_i` is low with both slots full, `mem_ce_o` stays low. No read is ever issued without a free slot, so no data is dropped.

## Test plan
- Reset, then base = 0x010, count = 1, `axi_rready_i` = 1, memory word 0x44444444_33333333_22222222_11111111 → `mem_ce_o` on cycle 1 with `mem_addr_o` = 0x010; beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on cycles 3–6; `axi_rlast_o` on cycle 6; `done_o` on cycle 7.
- Count = 4, `axi_rready_i` = 1 → 16 consecutive beats on cycles 3–18 with no gaps; exactly 4 reads to addresses base..base+3; `done_o` on cycle 19.
- Count = 3 with `axi_rready_i` toggling 1,0,0,1 repeating → `axi_rdata_o` stable while stalled; never more than 2 words outstanding; 12 beats in order; `axi_rlast_o` only on beat 12.
- Base = 0x3FE, count = 3 → read addresses 0x3FE, 0x3FF, 0x000.
- Count = 0 → `done_o` on cycle 1; no `mem_ce_o`, no `axi_rvalid_o`. A second `start_i` asserted while busy during a count = 2 transfer → ignored, exactly 8 beats produced.
- `rst` asserted on cycle 5 of a count = 4 transfer → all outputs 0 on the next cycle; no `done_o`; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/mem_to_axi_unpacker.sv
// mem_to_axi_unpacker
//
// Streams memory words out as AXI read-data beats. Each MEM_DATA_WIDTH word
// read from on-chip memory becomes four AXI_DATA_WIDTH beats, least-significant
// beat first. A two-slot word buffer lets the next word be fetched while the
// current one is streaming, so a continuously ready sink sees one beat per
// cycle with no gaps between words.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start_i         one-cycle transfer request, accepted only when idle
//   base_addr_i     first word address, latched on an accepted start
//   word_cnt_i      number of words to stream, latched on an accepted start
//   busy_o          high while a transfer is running
//   done_o          one-cycle pulse when a transfer ends
//   mem_ce_o        memory read enable
//   mem_addr_o      memory read address (0 when no read is issued)
//   mem_rdata_i     memory read data, valid the cycle after mem_ce_o
//   axi_rdata_o     beat data (0 when axi_rvalid_o is low)
//   axi_rvalid_o    beat valid
//   axi_rlast_o     last beat of the transfer
//   axi_rready_i    downstream ready

module mem_to_axi_unpacker #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int MEM_DATA_WIDTH = 128,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]      word_cnt_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      mem_ce_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i,
  output logic [AXI_DATA_WIDTH-1:0] axi_rdata_o,
  output logic                      axi_rvalid_o,
  output logic                      axi_rlast_o,
  input  logic                      axi_rready_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                    state;
  logic [MEM_ADDR_WIDTH-1:0] fetch_addr;   // next address to read, wraps naturally
  logic [LEN_WIDTH-1:0]      fetch_left;   // words not yet requested from memory
  logic [LEN_WIDTH-1:0]      stream_left;  // words not yet fully streamed
  logic [1:0]                occ;          // filled slots plus reads in flight
  logic                      rd_pending;   // a read was issued last cycle
  logic                      head;         // slot currently streaming
  logic                      tail;         // slot receiving the next read
  logic [1:0]                slot_vld;
  logic [1:0]                beat;         // beat index within the head word
  logic [MEM_DATA_WIDTH-1:0] slot_data [2];

  logic                      issue;
  logic                      hs;
  logic                      pop;
  logic [AXI_DATA_WIDTH-1:0] head_beats [4];

  // A read may only be issued into a guaranteed-free slot; the occupancy
  // value from the start of the cycle is used, so a same-cycle pop never
  // makes room early.
  assign issue = (state == S_RUN) && (occ != 2'd2) && (fetch_left != '0);
  assign hs    = axi_rvalid_o && axi_rready_i;
  assign pop   = hs && (beat == 2'd3);

  assign mem_ce_o   = issue;
  assign mem_addr_o = issue ? fetch_addr : '0;

  for (genvar b = 0; b < 4; b++) begin : g_beats
    assign head_beats[b] = slot_data[head][b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  end

  assign axi_rvalid_o = slot_vld[head];
  assign axi_rlast_o  = axi_rvalid_o && (beat == 2'd3) &&
                        (stream_left == LEN_WIDTH'(1));

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    axi_rdata_o = '0;
    if (axi_rvalid_o) axi_rdata_o = head_beats[beat];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fetch_addr  <= '0;
      fetch_left  <= '0;
      stream_left <= '0;
      occ         <= 2'd0;
      rd_pending  <= 1'b0;
      head        <= 1'b0;
      tail        <= 1'b0;
      slot_vld    <= 2'b00;
      beat        <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            if (word_cnt_i != '0) begin
              fetch_addr  <= base_addr_i;
              fetch_left  <= word_cnt_i;
              stream_left <= word_cnt_i;
              busy_o      <= 1'b1;
              state       <= S_RUN;
            end else begin
              done_o <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            fetch_addr <= fetch_addr + 1'b1;
            fetch_left <= fetch_left - 1'b1;
          end
          if (pop) begin
            stream_left <= stream_left - 1'b1;
            if (stream_left == LEN_WIDTH'(1)) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      case ({issue, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase

      rd_pending <= issue;

      // Fill and drain always touch different slots: the tail slot is empty
      // whenever a read lands, the head slot is full whenever it pops.
      if (rd_pending) begin
        slot_vld[tail] <= 1'b1;
        tail           <= ~tail;
      end
      if (pop) begin
        slot_vld[head] <= 1'b0;
        head           <= ~head;
      end
      if (hs) beat <= beat + 2'd1;
    end
  end

  // NOTE: the slot payload has no reset; slot_vld gates every use of it, so
  // clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (rd_pending) slot_data[tail] <= mem_rdata_i;
  end

endmodule

// File: tb/tb_mem_to_axi_unpacker.sv
// Self-checking bench for mem_to_axi_unpacker. A memory responder returns
// random words, a negedge monitor records every beat, read and done pulse,
// and each scenario task compares the record with the expected stream built
// directly from the memory contents.

module tb_mem_to_axi_unpacker;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [9:0]   base_addr_i;
  logic [7:0]   word_cnt_i;
  logic         busy_o;
  logic         done_o;
  logic         mem_ce_o;
  logic [9:0]   mem_addr_o;
  logic [127:0] mem_rdata_i;
  logic [31:0]  axi_rdata_o;
  logic         axi_rvalid_o;
  logic         axi_rlast_o;
  logic         axi_rready_i;

  mem_to_axi_unpacker #(
    .AXI_DATA_WIDTH(32),
    .MEM_DATA_WIDTH(128),
    .MEM_ADDR_WIDTH(10),
    .LEN_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .base_addr_i(base_addr_i),
    .word_cnt_i(word_cnt_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .mem_ce_o(mem_ce_o),
    .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i),
    .axi_rdata_o(axi_rdata_o),
    .axi_rvalid_o(axi_rvalid_o),
    .axi_rlast_o(axi_rlast_o),
    .axi_rready_i(axi_rready_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data appears the cycle after the read; garbage otherwise.
  logic [127:0] mem [1024];
  always @(posedge clk) begin
    if (mem_ce_o) mem_rdata_i <= mem[mem_addr_o];
    else          mem_rdata_i <= {$urandom, $urandom, $urandom, $urandom};
  end

  // Monitor record, indexed by cycle relative to the start request.
  typedef struct {
    int          rel;
    logic [31:0] data;
    logic        last;
  } beat_t;

  int          t0 = 0;
  beat_t       beat_q[$];
  int          read_cyc_q[$];
  logic [9:0]  read_addr_q[$];
  int          done_q[$];
  logic        busy_q[$];
  int          stall_viol, zero_viol, max_out, mon_reads, mon_hs;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;
  int          rel_now;

  task automatic clear_mon();
    beat_q.delete(); read_cyc_q.delete(); read_addr_q.delete();
    done_q.delete(); busy_q.delete();
    stall_viol = 0; zero_viol = 0; max_out = 0; mon_reads = 0; mon_hs = 0;
    prev_stall = 1'b0;
  endtask

  always @(negedge clk) begin
    rel_now = cyc - t0;
    busy_q.push_back(busy_o);
    if (mem_ce_o) begin
      read_cyc_q.push_back(rel_now);
      read_addr_q.push_back(mem_addr_o);
      mon_reads++;
    end
    // Words requested but not yet fully handed over downstream.
    if (mon_reads - mon_hs / 4 > max_out) max_out = mon_reads - mon_hs / 4;
    if (axi_rvalid_o && axi_rready_i) begin
      beat_q.push_back('{rel_now, axi_rdata_o, axi_rlast_o});
      mon_hs++;
    end
    if (!axi_rvalid_o && (axi_rdata_o !== 32'd0)) zero_viol++;
    if (prev_stall && (!axi_rvalid_o || axi_rdata_o !== prev_data ||
                       axi_rlast_o !== prev_last)) stall_viol++;
    prev_stall = axi_rvalid_o && !axi_rready_i;
    prev_data  = axi_rdata_o;
    prev_last  = axi_rlast_o;
    if (done_o) done_q.push_back(rel_now);
  end

  // Reference: beat i of a transfer is 32-bit lane i%4 of word base + i/4.
  function automatic logic [31:0] exp_beat(logic [9:0] base, int i);
    logic [9:0]   a;
    logic [127:0] w;
    a = base + 10'(i / 4);
    w = mem[a];
    return w[32*(i%4) +: 32];
  endfunction

  function automatic logic ready_for(int mode, int rel);
    logic [3:0] pat;
    pat = 4'b1001;  // rel%4 = 0,1,2,3 -> 1,0,0,1
    case (mode)
      0:       return 1'b1;
      1:       return pat[3 - (rel % 4)];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Issues one start at relative cycle 0 and runs until done is seen or the
  // budget expires. A second start can be injected at cycle extra_rel.
  task automatic run_xfer(input logic [9:0] base, input int cnt, input int mode,
                          input int extra_rel, input int budget, input string name);
    @(posedge clk); #1;
    t0 = cyc;
    clear_mon();
    start_i      = 1'b1;
    base_addr_i  = base;
    word_cnt_i   = 8'(cnt);
    axi_rready_i = ready_for(mode, 0);
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      start_i = (i == extra_rel);
      if (i == extra_rel) begin
        base_addr_i = ~base;
        word_cnt_i  = 8'd5;
      end
      axi_rready_i = ready_for(mode, i);
      if (done_q.size() > 0) break;
    end
    start_i = 1'b0;
    total++;
    if (done_q.size() !== 1) begin
      bad++;
      $display("FAIL %s done_count: got %0d want 1", name, done_q.size());
    end
  endtask

  // Compares the recorded transfer with the expected stream. With timed set,
  // the ready-always cycle positions are checked too.
  task automatic compare_stream(input string name, input logic [9:0] base,
                                input int cnt, input bit timed);
    int nbeats, first_bad, d;
    logic [9:0] ea;
    nbeats = 4 * cnt;

    total++;
    if (beat_q.size() !== nbeats) begin
      bad++;
      $display("FAIL %s beat_count: got %0d want %0d", name, beat_q.size(), nbeats);
    end

    first_bad = -1;
    for (int i = 0; i < beat_q.size() && i < nbeats; i++)
      if (first_bad < 0 && (beat_q[i].data !== exp_beat(base, i) ||
                            beat_q[i].last !== (i == nbeats - 1)))
        first_bad = i;
    total++;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL %s beat_data: beat %0d got %h last=%b want %h last=%b", name,
               first_bad, beat_q[first_bad].data, beat_q[first_bad].last,
               exp_beat(base, first_bad), first_bad == nbeats - 1);
    end

    first_bad = -1;
    for (int i = 0; i < read_addr_q.size(); i++) begin
      ea = base + 10'(i);
      if (first_bad < 0 && read_addr_q[i] !== ea) first_bad = i;
    end
    total++;
    if (read_addr_q.size() !== cnt || first_bad >= 0) begin
      bad++;
      $display("FAIL %s reads: got %0d reads (first bad idx %0d) want %0d from %h",
               name, read_addr_q.size(), first_bad, cnt, base);
    end

    total++;
    if (max_out > 2) begin
      bad++;
      $display("FAIL %s outstanding: got %0d want <=2", name, max_out);
    end

    total++;
    if (stall_viol !== 0 || zero_viol !== 0) begin
      bad++;
      $display("FAIL %s stability: stall_viol=%0d zero_viol=%0d want 0/0",
               name, stall_viol, zero_viol);
    end

    if (timed && done_q.size() > 0) begin
      d = done_q[0];
      total++;
      if (d !== 4 * cnt + 3) begin
        bad++;
        $display("FAIL %s done_cycle: got %0d want %0d", name, d, 4 * cnt + 3);
      end
      total++;
      if (read_cyc_q.size() == 0 || read_cyc_q[0] !== 1) begin
        bad++;
        $display("FAIL %s first_read_cycle: got %0d want 1", name,
                 read_cyc_q.size() ? read_cyc_q[0] : -1);
      end
      first_bad = -1;
      for (int i = 0; i < beat_q.size(); i++)
        if (first_bad < 0 && beat_q[i].rel !== 3 + i) first_bad = i;
      total++;
      if (first_bad >= 0) begin
        bad++;
        $display("FAIL %s beat_cycle: beat %0d got cycle %0d want %0d", name,
                 first_bad, beat_q[first_bad].rel, 3 + first_bad);
      end
      first_bad = -1;
      for (int i = 0; i <= d && i < busy_q.size(); i++)
        if (first_bad < 0 && busy_q[i] !== (i >= 1 && i < d)) first_bad = i;
      total++;
      if (first_bad >= 0 || busy_q.size() <= d) begin
        bad++;
        $display("FAIL %s busy: wrong at cycle %0d (done at %0d)", name, first_bad, d);
      end
    end else if (done_q.size() > 0 && beat_q.size() > 0) begin
      total++;
      if (done_q[0] !== beat_q[beat_q.size()-1].rel + 1) begin
        bad++;
        $display("FAIL %s done_after_last: got %0d want %0d", name, done_q[0],
                 beat_q[beat_q.size()-1].rel + 1);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({busy_o, done_o, mem_ce_o, mem_addr_o, axi_rdata_o, axi_rvalid_o,
         axi_rlast_o} !== '0) begin
      bad++;
      $display("FAIL %s outputs: busy=%b done=%b ce=%b addr=%h rdata=%h rvalid=%b rlast=%b want all 0",
               name, busy_o, done_o, mem_ce_o, mem_addr_o, axi_rdata_o,
               axi_rvalid_o, axi_rlast_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; base_addr_i = '0; word_cnt_i = '0;
    axi_rready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    mem[10'h010] = 128'h44444444_33333333_22222222_11111111;
    run_xfer(10'h010, 1, 0, -1, 20, "single");
    compare_stream("single", 10'h010, 1, 1'b1);
    total++;
    if (beat_q.size() !== 4 || beat_q[0].data !== 32'h11111111 ||
        beat_q[3].data !== 32'h44444444 || !beat_q[3].last) begin
      bad++;
      $display("FAIL single_literal: beats=%0d b0=%h b3=%h want 4 11111111 44444444",
               beat_q.size(), beat_q.size() ? beat_q[0].data : 32'h0,
               beat_q.size() > 3 ? beat_q[3].data : 32'h0);
    end
  endtask

  task automatic test_burst4();
    logic [9:0] b;
    b = 10'($urandom_range(0, 1000));
    run_xfer(b, 4, 0, -1, 40, "burst4");
    compare_stream("burst4", b, 4, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [9:0] b;
    b = 10'($urandom_range(0, 1000));
    run_xfer(b, 3, 1, -1, 100, "backpressure");
    compare_stream("backpressure", b, 3, 1'b0);
  endtask

  task automatic test_wrap();
    run_xfer(10'h3FE, 3, 0, -1, 40, "wrap");
    compare_stream("wrap", 10'h3FE, 3, 1'b1);
    total++;
    if (read_addr_q.size() !== 3 || read_addr_q[2] !== 10'h000) begin
      bad++;
      $display("FAIL wrap_addr: got %0d reads last=%h want 3 reads last=000",
               read_addr_q.size(), read_addr_q.size() ? read_addr_q[read_addr_q.size()-1] : 10'h0);
    end
  endtask

  task automatic test_zero_len();
    int busy_seen;
    run_xfer(10'h123, 0, 0, -1, 10, "zero_len");
    total++;
    if (done_q.size() == 0 || done_q[0] !== 1) begin
      bad++;
      $display("FAIL zero_len done_cycle: got %0d want 1", done_q.size() ? done_q[0] : -1);
    end
    busy_seen = 0;
    foreach (busy_q[i]) if (busy_q[i]) busy_seen++;
    total++;
    if (read_addr_q.size() !== 0 || beat_q.size() !== 0 || busy_seen !== 0) begin
      bad++;
      $display("FAIL zero_len activity: reads=%0d beats=%0d busy_cycles=%0d want 0/0/0",
               read_addr_q.size(), beat_q.size(), busy_seen);
    end
  endtask

  task automatic test_ignored_start();
    logic [9:0] b;
    b = 10'($urandom_range(0, 1000));
    run_xfer(b, 2, 0, 4, 40, "ignored_start");
    compare_stream("ignored_start", b, 2, 1'b1);
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    t0 = cyc;
    clear_mon();
    start_i = 1'b1; base_addr_i = 10'h200; word_cnt_i = 8'd4; axi_rready_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    done_q.delete();
    repeat (30) @(posedge clk);
    total++;
    if (done_q.size() !== 0) begin
      bad++;
      $display("FAIL mid_reset no_done: got %0d pulses want 0", done_q.size());
    end
    run_xfer(10'h055, 2, 0, -1, 30, "after_reset");
    compare_stream("after_reset", 10'h055, 2, 1'b1);
  endtask

  task automatic test_random();
    logic [9:0] b;
    int n;
    for (int t = 0; t < 5; t++) begin
      b = 10'($urandom);
      n = $urandom_range(1, 6);
      run_xfer(b, n, 2, -1, 40 * n + 40, "random");
      compare_stream("random", b, n, 1'b0);
    end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_single();
    test_burst4();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_ignored_start();
    test_mid_reset();
    test_random();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
